// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch control: next-PC selection, wrong-path squash,
// and a latency-matched validity pipeline for instruction-memory reads.
module pc_fetch_ctrl #(
    parameter int PC_W     = 9,
    parameter int IMEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            stall,
    input  logic            Branch_signal,
    input  logic [PC_W-1:0] Branch_target,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic [15:0]     br_taken_cnt
);

    localparam logic [0:0] ST_HALT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state_r;
    logic [0:0]          state_nxt_s;
    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     pc_nxt_s;
    logic                run_s;
    logic                redirect_s;
    logic                clear_s;
    logic                issue_s;
    logic [IMEM_LAT-1:0] vld_r;
    logic [PC_W-1:0]     addr_r [IMEM_LAT];
    logic [15:0]         cnt_r;

    // Control decode; branch outranks jump, both outrank stall and the halt request.
    always_comb begin
        run_s      = (state_r == ST_RUN);
        redirect_s = run_s & (Branch_signal | jump_en);
        clear_s    = ~run_s | ~en | redirect_s;
        issue_s    = ~clear_s & ~stall;
        pc_nxt_s   = pc_r;
        if (run_s) begin
            if (Branch_signal) begin
                pc_nxt_s = Branch_target;
            end else if (jump_en) begin
                pc_nxt_s = jump_target;
            end else if (stall || !en) begin
                pc_nxt_s = pc_r;
            end else begin
                pc_nxt_s = pc_r + PC_W'(1);
            end
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Run/halt state transition.
    always_comb begin
        state_nxt_s = ST_HALT;
        case (state_r)
            ST_HALT: state_nxt_s = en ? ST_RUN : ST_HALT;
            ST_RUN:  state_nxt_s = en ? ST_RUN : ST_HALT;
            default: state_nxt_s = ST_HALT;
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HALT;
            pc_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Validity pipeline: a stall freezes it so the pending word is re-presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMEM_LAT; i++) begin
                vld_r[i]  <= 1'b0;
                addr_r[i] <= '0;
            end
        end else if (clear_s) begin
            for (int i = 0; i < IMEM_LAT; i++) begin
                vld_r[i]  <= 1'b0;
                addr_r[i] <= '0;
            end
        end else if (issue_s) begin
            vld_r[0]  <= 1'b1;
            addr_r[0] <= pc_r;
            for (int i = 1; i < IMEM_LAT; i++) begin
                vld_r[i]  <= vld_r[i-1];
                addr_r[i] <= addr_r[i-1];
            end
        end
    end

    // Saturating taken-branch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (run_s && Branch_signal && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign pc           = pc_r;
    assign imem_addr    = pc_r;
    assign if_valid     = vld_r[IMEM_LAT-1];
    assign if_pc        = addr_r[IMEM_LAT-1];
    assign flush_ifid   = run_s & (Branch_signal | jump_en);
    assign flush_idex   = run_s & Branch_signal;
    assign br_taken_cnt = cnt_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: two instances (read latency 1 and 3) share one
// stimulus stream and are compared against a fetch-history reference model.
module tb_pc_fetch_ctrl;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            stall;
    logic            br;
    logic [PC_W-1:0] bt;
    logic            jmp;
    logic [PC_W-1:0] jt;

    logic [PC_W-1:0] imem_addr1, pc1, if_pc1, imem_addr3, pc3, if_pc3;
    logic            if_valid1, fi1, fe1, if_valid3, fi3, fe3;
    logic [15:0]     cnt1, cnt3;

    int tests_run;
    int tests_failed;

    // Reference model: pc/run/count plus a history of issued fetches.
    // Fetch number k is delivered once L further fetches have been issued,
    // unless a redirect or halt happened after it (m_kill).
    int m_run, m_pc, m_cnt, m_adv, m_kill;
    int m_hist [int];

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.PC_W(PC_W), .IMEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
        .Branch_signal(br), .Branch_target(bt), .jump_en(jmp), .jump_target(jt),
        .imem_addr(imem_addr1), .pc(pc1), .if_valid(if_valid1), .if_pc(if_pc1),
        .flush_ifid(fi1), .flush_idex(fe1), .br_taken_cnt(cnt1)
    );

    pc_fetch_ctrl #(.PC_W(PC_W), .IMEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
        .Branch_signal(br), .Branch_target(bt), .jump_en(jmp), .jump_target(jt),
        .imem_addr(imem_addr3), .pc(pc3), .if_valid(if_valid3), .if_pc(if_pc3),
        .flush_ifid(fi3), .flush_idex(fe3), .br_taken_cnt(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_pc   = 0;
        m_cnt  = 0;
        m_adv  = 0;
        m_kill = 0;
        m_hist.delete();
    endtask

    function automatic bit exp_valid(input int lat);
        return (m_adv - lat) >= m_kill;
    endfunction

    task automatic check_outs();
        chk("pc1", 32'(pc1), m_pc);
        chk("imem1", 32'(imem_addr1), m_pc);
        chk("cnt1", 32'(cnt1), m_cnt);
        chk("vld1", 32'(if_valid1), 32'(exp_valid(1)));
        if (exp_valid(1)) chk("ifpc1", 32'(if_pc1), m_hist[m_adv-1]);
        chk("pc3", 32'(pc3), m_pc);
        chk("imem3", 32'(imem_addr3), m_pc);
        chk("cnt3", 32'(cnt3), m_cnt);
        chk("vld3", 32'(if_valid3), 32'(exp_valid(3)));
        if (exp_valid(3)) chk("ifpc3", 32'(if_pc3), m_hist[m_adv-3]);
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic cycle(input logic e, input logic s, input logic b, input logic [PC_W-1:0] bti,
                         input logic j, input logic [PC_W-1:0] jti, input bit chk_on);
        bit redirect;
        en = e; stall = s; br = b; bt = bti; jmp = j; jt = jti;
        #1;
        if (chk_on) begin
            chk("flush_ifid1", 32'(fi1), 32'(m_run != 0 && (b || j)));
            chk("flush_idex1", 32'(fe1), 32'(m_run != 0 && b));
            chk("flush_ifid3", 32'(fi3), 32'(m_run != 0 && (b || j)));
            chk("flush_idex3", 32'(fe3), 32'(m_run != 0 && b));
        end
        redirect = (m_run != 0) && (b || j);
        if (m_run != 0 && e && !redirect && !s) begin
            m_hist[m_adv] = m_pc;
            m_adv++;
        end
        if (m_run == 0 || !e || redirect) m_kill = m_adv;
        if (m_run != 0) begin
            if (b) begin
                m_pc = int'(bti);
                if (m_cnt < 65535) m_cnt++;
            end else if (j) begin
                m_pc = int'(jti);
            end else if (e && !s) begin
                m_pc = (m_pc + 1) % 512;
            end
        end
        m_run = e ? 1 : 0;
        @(posedge clk);
        #1;
        if (chk_on) check_outs();
    endtask

    // Asynchronous reset in the middle of a branch+jump cycle.
    task automatic async_rst();
        en = 1'b1; stall = 1'b0; br = 1'b1; bt = 9'h033; jmp = 1'b1; jt = 9'h055;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pc1", 32'(pc1), 32'd0);
        chk("rst_imem1", 32'(imem_addr1), 32'd0);
        chk("rst_vld1", 32'(if_valid1), 32'd0);
        chk("rst_ifpc1", 32'(if_pc1), 32'd0);
        chk("rst_fi1", 32'(fi1), 32'd0);
        chk("rst_fe1", 32'(fe1), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_pc3", 32'(pc3), 32'd0);
        chk("rst_vld3", 32'(if_valid3), 32'd0);
        chk("rst_fi3", 32'(fi3), 32'd0);
        chk("rst_cnt3", 32'(cnt3), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        en = 1'b0; br = 1'b0; jmp = 1'b0;
        rst_n = 1'b1;
        check_outs();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0; en = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0;
        bt = 9'h000; jt = 9'h000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        chk("reset_ifpc1", 32'(if_pc1), 32'd0);
        chk("reset_fi1", 32'(fi1), 32'd0);
        rst_n = 1'b1;

        // Start-up: first word valid one latency after the first issue.
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        chk("s1_vld_e0", 32'(if_valid1), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
            chk("s1_ifpc", 32'(if_pc1), 32'(k));
            chk("s1_vld", 32'(if_valid1), 32'd1);
        end
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        chk("s2_pc5", 32'(pc1), 32'h005);

        // Taken branch from 0x05 to 0x40.
        cycle(1'b1, 1'b0, 1'b1, 9'h040, 1'b0, 9'h000, 1'b1);
        chk("s2_pc40", 32'(pc1), 32'h040);
        chk("s2_vld_low", 32'(if_valid1), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        chk("s2_ifpc1", 32'(if_pc1), 32'h040);
        chk("s2_vld3_low", 32'(if_valid3), 32'd0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        chk("s2_ifpc3", 32'(if_pc3), 32'h040);
        chk("s2_vld3", 32'(if_valid3), 32'd1);

        // Branch + jump + stall together: branch wins.
        cycle(1'b1, 1'b1, 1'b1, 9'h010, 1'b1, 9'h020, 1'b1);
        chk("s3_pc", 32'(pc1), 32'h010);

        // Stall held three cycles at 0x07.
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 9'h004, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
            chk("s4_pc", 32'(pc1), 32'h007);
            chk("s4_imem3", 32'(imem_addr3), 32'h007);
            chk("s4_ifpc1", 32'(if_pc1), 32'h006);
            chk("s4_ifpc3", 32'(if_pc3), 32'h004);
        end
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        chk("s4_resume", 32'(pc1), 32'h008);

        // Wrap from 0x1FF to 0x000.
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 9'h1FE, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        chk("s5_pc1ff", 32'(pc1), 32'h1FF);
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        chk("s5_wrap", 32'(pc1), 32'h000);

        // en low mid-stream freezes pc and drops validity.
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        chk("s6_pc_frozen", 32'(pc1), 32'h001);
        chk("s6_vld", 32'(if_valid1), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 9'h0AA, 1'b0, 9'h000, 1'b1);
        chk("s6_halt_ignores_br", 32'(pc1), 32'h001);
        // en drop during a redirect: target still loaded.
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 9'h0BB, 1'b0, 9'h000, 1'b1);
        chk("s6_halt_redirect", 32'(pc1), 32'h0BB);

        // Randomized stream.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_rst();
            end else begin
                cycle(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 3) == 0),
                      logic'($urandom_range(0, 7) == 0), 9'($urandom_range(0, 511)),
                      logic'($urandom_range(0, 7) == 0), 9'($urandom_range(0, 511)), 1'b1);
            end
        end

        // Saturation of the taken-branch counter.
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
        for (int n = 0; n < 65537; n++) begin
            cycle(1'b1, 1'b0, 1'b1, 9'h040, 1'b0, 9'h000, 1'b0);
        end
        check_outs();
        chk("sat_cnt1", 32'(cnt1), 32'h0000FFFF);
        chk("sat_cnt3", 32'(cnt3), 32'h0000FFFF);

        // Reset asserted mid-redirect.
        async_rst();
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-control stage that consumes the branch decision produced by the EX-stage zero-test branch detector. Holds the PC, drives the synchronous instruction-memory address, redirects on taken branches and jumps, and squashes wrong-path instructions already in the IF/ID and ID/EX registers. Tracks instruction-memory read latency so the fetched word is marked valid only when it belongs to the current path.

## Interface
- PC_W, 9: PC / instruction-memory address width (word addressed).
- IMEM_LAT, 1: instruction-memory read latency in cycles (1..4).
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low halts fetch.
- stall  in  1  load-use/hazard stall from decode; freezes PC.
- Branch_signal  in  1  taken-branch from EX-stage BEZ/BNEZ detect.
- Branch_target  in  PC_W  branch destination.
- jump_en  in  1  unconditional jump resolved in ID.
- jump_target  in  PC_W  jump destination.
- imem_addr  out  PC_W  address presented to instruction memory (equals pc).
- pc  out  PC_W  current fetch PC.
- if_valid  out  1  instruction-memory data this cycle is on the correct path.
- if_pc  out  PC_W  PC of the word qualified by if_valid.
- flush_ifid  out  1  squash IF/ID register this edge.
- flush_idex  out  1  squash ID/EX register this edge.
- br_taken_cnt  out  16  count of taken branches, saturating.

## Operation
- States: HALT (reset state) and RUN. HALT→RUN at an edge with en=1; RUN→HALT at an edge with en=0. In HALT pc holds, no addresses are issued, redirects are ignored.
- Next-PC priority in RUN: Branch_signal → Branch_target; else jump_en → jump_target; else stall → hold; else pc+1. Arithmetic is mod 2^PC_W; pc+1 from all-ones wraps to 0.
- Branch overrides stall and jump (the stalled/jumping instruction is younger, thus wrong-path).
- flush_ifid = RUN & (Branch_signal | jump_en); flush_idex = RUN & Branch_signal. Combinational, same cycle as the cause.
- Validity pipeline: IMEM_LAT-deep shift register of {issued, addr}. An entry is issued=1 when RUN, no stall and no redirect this cycle. On redirect (branch or jump) all in-flight entries are cleared at the same edge. When stalled, the pipeline holds (does not shift) so the pending word is re-presented; imem_addr stays constant so memory output is stable.
- if_valid/if_pc are the tail of the shift register. Entering HALT clears the pipeline.
- br_taken_cnt increments on each RUN cycle with Branch_signal=1; saturates at 0xFFFF; cleared only by reset.

## Timing
- Reset (async assert, sync-free release): state=HALT, pc=0, imem_addr=0, pipeline cleared, if_valid=0, if_pc=0, flush_*=0, br_taken_cnt=0.
- First valid word: en high at edge E0 (→RUN), address 0 issued in cycle after E0, if_valid=1 with if_pc=0 IMEM_LAT cycles later.
- Redirect latency: Branch_signal in cycle t → pc=Branch_target after edge t; target word valid IMEM_LAT cycles after that. Words issued before the redirect never raise if_valid.
- Simultaneous Branch_signal and jump_en: branch wins, both flushes asserted, jump_target ignored.
- Stall with Branch_signal: redirect taken, stall ignored for PC.
- en drops during redirect cycle: HALT wins, pc still loads target (redirect recorded), pipeline cleared.
- Reset asserted mid-operation: all outputs to reset values immediately, no further flush pulses.

## Test plan
- Reset then en=1, no stalls, IMEM_LAT=1 → if_pc sequence 0,1,2,3 on consecutive cycles, if_valid=1 from first fetch onward.
- Branch_signal=1 with Branch_target=0x40 while pc=0x05 → flush_ifid=flush_idex=1 that cycle, pc=0x40 next, if_valid low for IMEM_LAT cycles, then if_pc=0x40.
- Branch_signal and jump_en both 1 (targets 0x10, 0x20) plus stall=1 → pc=0x10, both flushes high, stall ignored.
- stall held 3 cycles at pc=0x07 → pc and imem_addr stay 0x07, if_valid/if_pc stable, resumes 0x08 after release; repeat with IMEM_LAT=3.
- pc=0x1FF (PC_W=9) free-running → next pc=0x000; 65537 taken branches → br_taken_cnt=0xFFFF.
- rst_n asserted mid-redirect and en toggled low → outputs return to reset values asynchronously; en low mid-stream freezes pc, if_valid=0 until RUN resumes.
